// File: rtl/ecg_cnn_pkg.sv
// Shared constants and the framer state encoding for the ECG CNN front end.
package ecg_cnn_pkg;

  localparam int unsigned ECG_N        = 32;
  localparam int unsigned ECG_HOP      = 16;
  localparam int unsigned ECG_SAMPLE_W = 16;
  localparam int unsigned ECG_CLASS_W  = 8;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    EVAL   = 2'd1,
    RESULT = 2'd2
  } framer_state_t;

endpackage

// File: rtl/ecg_window_shreg.sv
// Sample shift register: new sample enters the top slot, index 0 holds the oldest.
module ecg_window_shreg #(
  parameter int unsigned N = 32,
  parameter int unsigned W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           shift_en,
  input  logic [W-1:0]   din,
  output logic [W*N-1:0] dout
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout <= '0;
    end else if (shift_en) begin
      dout <= {din, dout[W*N-1:W]};
    end
  end

endmodule

// File: rtl/ecg_window_framer.sv
// Frames FIR-filtered ECG samples into N-sample windows and captures the classifier result.
// Define ECG_FRAMER_OVERLAP_EN to keep N-HOP samples between windows (sliding windows).
module ecg_window_framer
  import ecg_cnn_pkg::*;
#(
  parameter int unsigned N   = ECG_N,
  parameter int unsigned HOP = ECG_HOP
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [ECG_SAMPLE_W-1:0]   s_data,
  output logic [ECG_SAMPLE_W*N-1:0] win_data,
  output logic                      win_valid,
  input  logic [ECG_CLASS_W-1:0]    class_in,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [ECG_CLASS_W-1:0]    res_class,
  output logic [7:0]                res_seq
);

  localparam int unsigned CW = $clog2(N + 1);

  if (N < 4 || HOP < 1 || HOP > N) begin : g_bad_cfg
    $error("ecg_window_framer: invalid N/HOP configuration");
  end

`ifdef ECG_FRAMER_OVERLAP_EN
  localparam logic [CW-1:0] REFILL = CW'(N - HOP);
`else
  localparam logic [CW-1:0] REFILL = '0;
`endif

  framer_state_t state, state_nxt;
  logic [CW-1:0] fill_cnt, fill_nxt;
  logic [7:0]    seq, seq_nxt;
  logic          shift_en;
  logic          capture;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FILL;
      fill_cnt  <= '0;
      seq       <= '0;
      res_class <= '0;
      res_seq   <= '0;
    end else begin
      state    <= state_nxt;
      fill_cnt <= fill_nxt;
      seq      <= seq_nxt;
      if (capture) begin
        res_class <= class_in;
        res_seq   <= seq;
      end
    end
  end

  // flush overrides every handshake, so it is decoded ahead of the state case
  always_comb begin
    state_nxt = state;
    fill_nxt  = fill_cnt;
    seq_nxt   = seq;
    shift_en  = 1'b0;
    capture   = 1'b0;
    if (flush) begin
      state_nxt = FILL;
      fill_nxt  = '0;
    end else begin
      case (state)
        FILL: begin
          if (s_valid) begin
            shift_en = 1'b1;
            fill_nxt = fill_cnt + 1'b1;
            if (fill_cnt == CW'(N - 1)) begin
              state_nxt = EVAL;
            end
          end
        end
        EVAL: begin
          capture   = 1'b1;
          state_nxt = RESULT;
        end
        RESULT: begin
          if (res_ready) begin
            state_nxt = FILL;
            fill_nxt  = REFILL;
            seq_nxt   = seq + 8'd1;
          end
        end
        default: begin
          state_nxt = FILL;
          fill_nxt  = '0;
        end
      endcase
    end
  end

  assign s_ready   = (state == FILL);
  assign win_valid = (state == EVAL) || (state == RESULT);
  assign res_valid = (state == RESULT);

  ecg_window_shreg #(
    .N (N),
    .W (ECG_SAMPLE_W)
  ) u_shreg (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (shift_en),
    .din      (s_data),
    .dout     (win_data)
  );

endmodule

// File: tb/tb_ecg_window_framer.sv
// Directed self-checking bench for ecg_window_framer (default N=32, HOP=16).
module tb_ecg_window_framer;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          s_valid;
  logic          s_ready;
  logic [15:0]   s_data;
  logic [511:0]  win_data;
  logic          win_valid;
  logic [7:0]    class_in;
  logic          res_valid;
  logic          res_ready;
  logic [7:0]    res_class;
  logic [7:0]    res_seq;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  ecg_window_framer #(
    .N   (32),
    .HOP (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .win_data  (win_data),
    .win_valid (win_valid),
    .class_in  (class_in),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_class (res_class),
    .res_seq   (res_seq)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] sample(input int unsigned k);
    return win_data[16*k +: 16];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] v);
    s_valid = 1'b1;
    s_data  = v;
    tick();
    s_valid = 1'b0;
  endtask

  logic [15:0] hold0, hold31;
  int unsigned cnt;

  initial begin
    rst_n = 1'b0; flush = 1'b0; s_valid = 1'b0; s_data = '0;
    class_in = '0; res_ready = 1'b0;
    repeat (2) tick();
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    chk("rst_win_valid", 32'(win_valid), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_class", 32'(res_class), 32'd0);
    chk("rst_res_seq", 32'(res_seq), 32'd0);
    chk("rst_win_zero", 32'(|win_data), 32'd0);
    rst_n = 1'b1;
    tick();

    // first window: 1..32 back-to-back
    for (int i = 1; i <= 32; i++) begin
      if (i == 32) chk("w1_pre_last_win_valid", 32'(win_valid), 32'd0);
      push(16'(i));
    end
    chk("w1_win_valid", 32'(win_valid), 32'd1);
    chk("w1_eval_res_valid", 32'(res_valid), 32'd0);
    chk("w1_eval_s_ready", 32'(s_ready), 32'd0);
    chk("w1_sample0", 32'(sample(0)), 32'd1);
    chk("w1_sample31", 32'(sample(31)), 32'd32);
    class_in = 8'hA5;
    tick();
    class_in = 8'h3C;
    chk("w1_res_valid", 32'(res_valid), 32'd1);
    chk("w1_res_class", 32'(res_class), 32'hA5);
    chk("w1_res_seq", 32'(res_seq), 32'd0);
    s_valid = 1'b1; s_data = 16'hBEEF;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_res_class", 32'(res_class), 32'hA5);
      chk("hold_s_ready", 32'(s_ready), 32'd0);
      chk("hold_res_valid", 32'(res_valid), 32'd1);
    end
    s_valid = 1'b0;
    chk("hold_sample0", 32'(sample(0)), 32'd1);
    chk("hold_sample31", 32'(sample(31)), 32'd32);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("consume_res_valid", 32'(res_valid), 32'd0);
    chk("consume_win_valid", 32'(win_valid), 32'd0);
    chk("consume_s_ready", 32'(s_ready), 32'd1);

    // second window
    for (int i = 33; i <= 48; i++) push(16'(i));
`ifdef ECG_FRAMER_OVERLAP_EN
    chk("w2_win_valid", 32'(win_valid), 32'd1);
    chk("w2_sample0", 32'(sample(0)), 32'd17);
    chk("w2_sample31", 32'(sample(31)), 32'd48);
`else
    chk("w2_half_win_valid", 32'(win_valid), 32'd0);
    for (int i = 49; i <= 64; i++) push(16'(i));
    chk("w2_win_valid", 32'(win_valid), 32'd1);
    chk("w2_sample0", 32'(sample(0)), 32'd33);
    chk("w2_sample31", 32'(sample(31)), 32'd64);
`endif
    class_in = 8'h11;
    tick();
    chk("w2_res_seq", 32'(res_seq), 32'd1);
    chk("w2_res_class", 32'(res_class), 32'h11);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;

    // flush with a simultaneous sample after 20 samples
    for (int i = 0; i < 20; i++) push(16'(100 + i));
    s_valid = 1'b1; s_data = 16'h03E7; flush = 1'b1;
    tick();
    s_valid = 1'b0; flush = 1'b0;
    chk("flush_sample31", 32'(sample(31)), 32'd119);
    chk("flush_win_valid", 32'(win_valid), 32'd0);
    chk("flush_s_ready", 32'(s_ready), 32'd1);
    for (int i = 0; i < 31; i++) push(16'(200 + i));
    chk("flush_31_win_valid", 32'(win_valid), 32'd0);
    push(16'd231);
    chk("flush_32_win_valid", 32'(win_valid), 32'd1);
    chk("flush_sample0", 32'(sample(0)), 32'd200);
    chk("flush_sample31", 32'(sample(31)), 32'd231);
    tick();
    chk("w3_res_seq", 32'(res_seq), 32'd2);
    // flush beats res_ready: result dropped, sequence unchanged
    flush = 1'b1; res_ready = 1'b1;
    tick();
    flush = 1'b0; res_ready = 1'b0;
    chk("flush_res_res_valid", 32'(res_valid), 32'd0);
    chk("flush_res_win_valid", 32'(win_valid), 32'd0);
    for (int i = 0; i < 32; i++) push(16'(300 + i));
    tick();
    chk("w4_res_valid", 32'(res_valid), 32'd1);
    chk("w4_res_seq", 32'(res_seq), 32'd2);

    // asynchronous reset while in RESULT
    #2 rst_n = 1'b0;
    #1;
    chk("arst_res_valid", 32'(res_valid), 32'd0);
    chk("arst_win_valid", 32'(win_valid), 32'd0);
    chk("arst_res_seq", 32'(res_seq), 32'd0);
    chk("arst_win_zero", 32'(|win_data), 32'd0);
    chk("arst_s_ready", 32'(s_ready), 32'd1);
    #10 rst_n = 1'b1;
    tick();

    // 257 windows: sequence runs 0..255 then wraps to 0
    for (int w = 0; w <= 256; w++) begin
      cnt = 0;
      while (!win_valid && cnt < 64) begin
        push(16'(w));
        cnt++;
      end
      if (!win_valid) begin
        chk("wrap_fill_timeout", 32'(win_valid), 32'd1);
        break;
      end
      class_in = 8'(w ^ 8'h5A);
      tick();
      chk("wrap_res_seq", 32'(res_seq), 32'(w % 256));
      if (w == 0 || w == 255 || w == 256)
        chk("wrap_res_class", 32'(res_class), 32'(8'(w ^ 8'h5A)));
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
